// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: issue-side hazard tracker for in-flight register writes.
// It stalls ID->EX issue on sources written by late (non-forwardable)
// producers, and on pending-write counter overflow.
// Optional build macro: SCOREBOARD_STATS_EN adds the stall_cycles counter output.

`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif

module hazard_scoreboard #(
  parameter int unsigned REG_NUM   = 32,
  parameter int unsigned CNT_WIDTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         issue_valid,
  input  logic [`REG_ADDR_WIDTH-1:0]   issue_rs1,
  input  logic                         issue_rs1_ren,
  input  logic [`REG_ADDR_WIDTH-1:0]   issue_rs2,
  input  logic                         issue_rs2_ren,
  input  logic [`REG_ADDR_WIDTH-1:0]   issue_rd,
  input  logic                         issue_rd_wen,
  input  logic                         issue_rd_late,
  input  logic                         wb_wen,
  input  logic [`REG_ADDR_WIDTH-1:0]   wb_waddr,
  input  logic                         flush,
`ifdef SCOREBOARD_STATS_EN
  output logic [31:0]                  stall_cycles,
`endif
  output logic                         issue_stall,
  output logic [REG_NUM-1:0]           reg_busy,
  output logic                         sb_err
);

  localparam int unsigned AW = `REG_ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [CNT_WIDTH-1:0] cnt_q [REG_NUM];
  logic [CNT_WIDTH-1:0] cnt_d [REG_NUM];
  logic [REG_NUM-1:0]   late_q;
  logic [REG_NUM-1:0]   late_d;
  logic [REG_NUM-1:0]   busy_d;
  logic                 err_d;
  logic                 hazard1;
  logic                 hazard2;
  logic                 overflow;
  logic                 fire;
  logic                 inc;
  logic                 dec;

  // Hazard detection against registered state only; WB is not bypassed.
  always_comb begin
    hazard1     = issue_rs1_ren && (issue_rs1 != '0) && late_q[issue_rs1];
    hazard2     = issue_rs2_ren && (issue_rs2 != '0) && late_q[issue_rs2];
    overflow    = issue_rd_wen && (issue_rd != '0) && (cnt_q[issue_rd] == CNT_MAX);
    issue_stall = issue_valid && (hazard1 || hazard2 || overflow);
    fire        = issue_valid && !issue_stall;
    inc         = fire && issue_rd_wen && (issue_rd != '0);
    dec         = wb_wen && (wb_waddr != '0);
  end

  // Next-state for counters, late bits, busy vector and the sticky error.
  always_comb begin
    cnt_d  = cnt_q;
    late_d = late_q;
    err_d  = sb_err;
    busy_d = '0;
    if (flush) begin
      for (int unsigned i = 0; i < REG_NUM; i++) cnt_d[i] = '0;
      late_d = '0;
    end else begin
      for (int unsigned i = 1; i < REG_NUM; i++) begin
        if (inc && (issue_rd == AW'(i))) begin
          late_d[i] = issue_rd_late;
          if (dec && (wb_waddr == AW'(i))) begin
            // Simultaneous issue and retire cancel out in the counter.
            if (cnt_q[i] == '0) err_d = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
          end
        end else if (dec && (wb_waddr == AW'(i))) begin
          if (cnt_q[i] == '0) begin
            err_d = 1'b1;
          end else begin
            cnt_d[i] = cnt_q[i] - CNT_WIDTH'(1);
            if (cnt_q[i] == CNT_WIDTH'(1)) late_d[i] = 1'b0;
          end
        end
      end
    end
    cnt_d[0]  = '0;
    late_d[0] = 1'b0;
    for (int unsigned i = 1; i < REG_NUM; i++) busy_d[i] = (cnt_d[i] != '0);
  end

  // State, busy vector and error flag share one clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < REG_NUM; i++) cnt_q[i] <= '0;
      late_q   <= '0;
      reg_busy <= '0;
      sb_err   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      late_q   <= late_d;
      reg_busy <= busy_d;
      sb_err   <= err_d;
    end
  end

`ifdef SCOREBOARD_STATS_EN
  // Free-running count of stalled cycles; survives flush.
  always_ff @(posedge clk) begin
    if (rst) stall_cycles <= '0;
    else if (issue_stall) stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard with an expectation queue.
module tb_hazard_scoreboard;

  localparam int unsigned REG_NUM = 32;
  localparam int unsigned AW      = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              issue_valid;
  logic [AW-1:0]     issue_rs1;
  logic              issue_rs1_ren;
  logic [AW-1:0]     issue_rs2;
  logic              issue_rs2_ren;
  logic [AW-1:0]     issue_rd;
  logic              issue_rd_wen;
  logic              issue_rd_late;
  logic              wb_wen;
  logic [AW-1:0]     wb_waddr;
  logic              flush;
  logic              issue_stall;
  logic [REG_NUM-1:0] reg_busy;
  logic              sb_err;
`ifdef SCOREBOARD_STATS_EN
  logic [31:0]       stall_cycles;
`endif

  int checks = 0;
  int fails  = 0;
  logic [31:0] exp_q [$];

  hazard_scoreboard #(.REG_NUM(REG_NUM), .CNT_WIDTH(2)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs1_ren(issue_rs1_ren),
    .issue_rs2(issue_rs2), .issue_rs2_ren(issue_rs2_ren),
    .issue_rd(issue_rd), .issue_rd_wen(issue_rd_wen), .issue_rd_late(issue_rd_late),
    .wb_wen(wb_wen), .wb_waddr(wb_waddr),
    .flush(flush),
`ifdef SCOREBOARD_STATS_EN
    .stall_cycles(stall_cycles),
`endif
    .issue_stall(issue_stall),
    .reg_busy(reg_busy),
    .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic push(input logic [31:0] e);
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL %s: observed %0h but no expected value queued", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic idle();
    issue_valid = 0; issue_rs1 = '0; issue_rs1_ren = 0; issue_rs2 = '0; issue_rs2_ren = 0;
    issue_rd = '0; issue_rd_wen = 0; issue_rd_late = 0; wb_wen = 0; wb_waddr = '0; flush = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue_wr(input logic [AW-1:0] rd, input logic late);
    idle(); issue_valid = 1; issue_rd = rd; issue_rd_wen = 1; issue_rd_late = late;
  endtask

  task automatic issue_rd1(input logic [AW-1:0] rs);
    idle(); issue_valid = 1; issue_rs1 = rs; issue_rs1_ren = 1;
  endtask

  task automatic do_wb(input logic [AW-1:0] a);
    idle(); wb_wen = 1; wb_waddr = a;
  endtask

  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    #1;
    push(32'd0); check("reset_busy", reg_busy);
    push(32'd0); check("reset_err", 32'(sb_err));
    push(32'd0); check("reset_stall", 32'(issue_stall));

    // Load to x5, then dependent read stalls until WB.
    issue_wr(5'd5, 1'b1); #1;
    push(32'd0); check("load5_stall", 32'(issue_stall));
    tick();
    issue_rd1(5'd5); issue_rd = 5'd6; issue_rd_wen = 1; wb_wen = 1; wb_waddr = 5'd5; #1;
    push(32'd1); check("use5_stall", 32'(issue_stall));
    push(32'd1); check("busy5_set", 32'(reg_busy[5]));
    tick();
    wb_wen = 0; #1;
    push(32'd0); check("use5_release", 32'(issue_stall));
    push(32'd0); check("busy5_clear", 32'(reg_busy[5]));
    tick();
    push(32'd1); check("busy6_set", 32'(reg_busy[6]));
    do_wb(5'd6); tick();
    push(32'd0); check("busy6_clear", 32'(reg_busy[6]));

    // Non-late producer never stalls the reader.
    issue_wr(5'd7, 1'b0); tick();
    idle(); issue_valid = 1; issue_rs2 = 5'd7; issue_rs2_ren = 1; #1;
    push(32'd0); check("alu7_nostall", 32'(issue_stall));
    push(32'd1); check("busy7_set", 32'(reg_busy[7]));
    tick();
    push(32'd1); check("busy7_hold", 32'(reg_busy[7]));
    do_wb(5'd7); tick();
    push(32'd0); check("busy7_clear", 32'(reg_busy[7]));

    // Youngest non-late writer shadows an older load.
    issue_wr(5'd3, 1'b1); tick();
    issue_wr(5'd3, 1'b0); #1;
    push(32'd0); check("rewrite3_stall", 32'(issue_stall));
    tick();
    issue_rd1(5'd3); #1;
    push(32'd0); check("read3_nostall", 32'(issue_stall));
    tick();
    do_wb(5'd3); tick();
    push(32'd1); check("busy3_after_wb1", 32'(reg_busy[3]));
    do_wb(5'd3); tick();
    push(32'd0); check("busy3_after_wb2", 32'(reg_busy[3]));

    // Counter overflow on x9.
    for (int k = 0; k < 3; k++) begin
      issue_wr(5'd9, 1'b0); tick();
    end
    issue_wr(5'd9, 1'b0); wb_wen = 1; wb_waddr = 5'd9; #1;
    push(32'd1); check("ovf9_stall", 32'(issue_stall));
    tick();
    wb_wen = 0; #1;
    push(32'd0); check("ovf9_release", 32'(issue_stall));
    tick();
    push(32'd1); check("ovf9_full_again", 32'(issue_stall));
    push(32'd1); check("busy9", 32'(reg_busy[9]));

    // Flush with a same-cycle WB clears everything without error.
    issue_wr(5'd4, 1'b1); tick();
    issue_rd1(5'd4); #1;
    push(32'd1); check("read4_stall", 32'(issue_stall));
    idle(); flush = 1; wb_wen = 1; wb_waddr = 5'd4; tick();
    issue_rd1(5'd4); #1;
    push(32'd0); check("flush_busy", reg_busy);
    push(32'd0); check("flush_err", 32'(sb_err));
    push(32'd0); check("flush_read4", 32'(issue_stall));

    // Spurious WB sets a sticky error; x0 is never tracked.
    do_wb(5'd12); tick();
    push(32'd1); check("err_set", 32'(sb_err));
    idle(); tick(); tick();
    push(32'd1); check("err_sticky", 32'(sb_err));
    issue_wr(5'd0, 1'b1); tick();
    issue_rd1(5'd0); #1;
    push(32'd0); check("x0_nostall", 32'(issue_stall));
    push(32'd0); check("x0_busy", 32'(reg_busy[0]));
    idle(); flush = 1; tick();
    push(32'd1); check("err_after_flush", 32'(sb_err));
    idle(); rst = 1; tick(); rst = 0;
    push(32'd0); check("err_after_rst", 32'(sb_err));

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
